fifo_drain_arb: RTL and testbench
=================================

Name: fifo_drain_arb

Overview:
- Round-robin read-side arbiter that drains NUM_SRC fifo_sync instances into one registered valid/ready output stream.
- Each grant is a burst of up to MAX_BURST words from one source. The burst ends early if that source goes empty.
- Sits between per-channel fifo_sync instances and a shared downstream consumer, for example a DMA or UART packetiser.
- Drives each FIFO's re directly. It never reads an empty FIFO.

Parameters:
NUM_SRC, 4, number of source FIFOs (2..16)
DATAWIDTH, 18, word width; must match the fifo_sync DATAWIDTH
MAX_BURST, 8, maximum words per grant (1..2^BURSTWIDTH)
SRCWIDTH, 2, width of the source index; must satisfy 2^SRCWIDTH >= NUM_SRC
BURSTWIDTH, 4, burst counter width

Ports:
clk  input  1  clock
reset_l  input  1  reset, asynchronous assert, active-low
enable  input  1  when low, no new grants are issued; a burst in progress completes
src_mask  input  NUM_SRC  per-source enable; a masked source is never granted
src_ne  input  NUM_SRC  registered not-empty from each fifo_sync (ne)
src_data  input  NUM_SRC*DATAWIDTH  registered head data from each fifo_sync (rd_data); source i occupies bits [i*DATAWIDTH +: DATAWIDTH]
src_re  output  NUM_SRC  combinational read enable to each fifo_sync (re)
out_data  output  DATAWIDTH  registered output word
out_src  output  SRCWIDTH  source index of out_data
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the word when out_valid && out_ready
busy  output  1  FSM is not in IDLE
grant  output  SRCWIDTH  currently or last granted source

Behaviour:
- Reset (reset_l low, asynchronous):
  - state=IDLE, out_valid=0, out_data=0, out_src=0, grant=0, busy=0, burst count=0.
  - Round-robin pointer last=NUM_SRC-1, so source 0 has first priority.
  - A reset mid-burst abandons the burst. No src_re is asserted while reset_l is low.
- Output register:
  - space = !out_valid || out_ready.
  - On a read: out_data<=src_data[grant], out_src<=grant, out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - Output latency is 1 cycle from src_re to out_valid.
  - A full stream runs at 1 word/clk while out_ready stays high.
- State IDLE:
  - Candidates are src_ne & src_mask, considered only when enable=1.
  - If any candidate exists, pick the first one searching from last+1 with wrap. Then grant<=idx, count<=0, go to XFER.
  - No src_re is asserted in IDLE. This costs one bubble cycle per arbitration.
- State XFER:
  - src_re[grant] = src_ne[grant] && space. All other src_re bits are 0.
  - On each read, count increments.
  - If a read occurs with count==MAX_BURST-1: last<=grant, go to IDLE.
  - If src_ne[grant]==0 with no read (source empty): last<=grant, go to IDLE, short burst.
  - Backpressure (space==0) holds XFER with count unchanged, indefinitely.
  - enable and src_mask are ignored mid-burst.
- Fairness:
  - Every masked-in, non-empty source is granted within NUM_SRC arbitrations.
  - A source re-requesting after its own burst is granted again only if no other candidate exists.
- Counter width: count is BURSTWIDTH bits and never wraps, because it terminates at MAX_BURST-1.
- Safety invariants:
  - src_re[i] implies src_ne[i].
  - src_re is one-hot or zero.
  - out_valid never drops without a handshake.
- Simultaneous events: in the same cycle, the output handshake and a new read load the register with no bubble. IDLE plus a new request decides the next grant that cycle.

Test Plan:
- Reset, then fill FIFO1 with 3 words A,B,C; out_ready=1, enable=1, mask=4'hF -> out stream A,B,C with out_src=1; burst ends empty; back to IDLE; src_re never asserted while src_ne[1]=0.
- All four FIFOs each hold 20 words, out_ready=1 -> grants 0,1,2,3,0,... Each full burst is 8 consecutive words with 1 bubble between bursts, for 80 words total.
- Only FIFO2 non-empty with 20 words -> bursts of 8, 8, 4, all with out_src=2 and an IDLE bubble between each.
- out_ready toggled 1010... during a burst -> out_data is held while out_valid && !out_ready; no word is lost or duplicated; order is preserved.
- src_mask=4'b1101 with all FIFOs non-empty -> source 1 is never granted; enable driven 0 mid-burst -> the current 8-word burst completes, then busy=0 until enable returns to 1.
- Assert reset_l low mid-burst (count=3) -> out_valid=0 and src_re=0 immediately, without waiting for a clock edge; after release, the first grant goes to source 0.

Source files
------------

// File: rtl/fifo_drain_arb_if.sv
// Source-side FIFO read port bundle plus the registered output stream of the drain arbiter.
// master = arbiter side, slave = FIFOs + downstream consumer.
interface fifo_drain_arb_if #(
  parameter int NUM_SRC   = 4,
  parameter int DATAWIDTH = 18,
  parameter int SRCWIDTH  = 2
);
  logic [NUM_SRC-1:0]           src_ne;
  logic [NUM_SRC*DATAWIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]           src_re;
  logic [DATAWIDTH-1:0]         out_data;
  logic [SRCWIDTH-1:0]          out_src;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    input  src_ne, src_data, out_ready,
    output src_re, out_data, out_src, out_valid
  );

  modport slave (
    output src_ne, src_data, out_ready,
    input  src_re, out_data, out_src, out_valid
  );
endinterface

// File: rtl/fifo_drain_arb.sv
// Round-robin burst drain of NUM_SRC fifo_sync read ports into one registered stream; 1 cycle src_re->out_valid.
// Backpressure holds the burst (count frozen) while the output register is full and not accepted.
module fifo_drain_arb #(
  parameter int NUM_SRC    = 4,
  parameter int DATAWIDTH  = 18,
  parameter int MAX_BURST  = 8,
  parameter int SRCWIDTH   = 2,
  parameter int BURSTWIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                enable,
  input  logic [NUM_SRC-1:0]  src_mask,
  fifo_drain_arb_if.master    bus,
  output logic                busy,
  output logic [SRCWIDTH-1:0] grant
);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t                r_state;
  logic [SRCWIDTH-1:0]   r_grant;
  logic [SRCWIDTH-1:0]   r_last;
  logic [BURSTWIDTH-1:0] r_count;
  logic                  r_busy;
  logic [DATAWIDTH-1:0]  r_out_data;
  logic [SRCWIDTH-1:0]   r_out_src;
  logic                  r_out_valid;

  logic                 w_space;
  logic                 w_rd;
  logic                 w_grant_ne;
  logic [DATAWIDTH-1:0] w_head;
  logic [NUM_SRC-1:0]   w_cand;
  logic                 w_found;
  logic [SRCWIDTH-1:0]  w_next;
  logic [NUM_SRC-1:0]   w_src_re;

  assign w_space = !r_out_valid || bus.out_ready;

  always_comb begin
    w_grant_ne = 1'b0;
    w_head     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == SRCWIDTH'(i)) begin
        w_grant_ne = bus.src_ne[i];
        w_head     = bus.src_data[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // reset_l gating keeps re low combinationally while reset is asserted
  assign w_rd = reset_l && (r_state == S_XFER) && w_grant_ne && w_space;

  always_comb begin
    w_src_re = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src_re[i] = w_rd && (r_grant == SRCWIDTH'(i));
    end
  end

  // First candidate searching from last+1 with wrap; the just-served source is checked last
  always_comb begin
    w_cand  = enable ? (bus.src_ne & src_mask) : '0;
    w_found = 1'b0;
    w_next  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!w_found && w_cand[i] && (i == (int'(r_last) + k) % NUM_SRC)) begin
          w_found = 1'b1;
          w_next  = SRCWIDTH'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= SRCWIDTH'(NUM_SRC - 1);
      r_count <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_next;
            r_count <= '0;
            r_state <= S_XFER;
            r_busy  <= 1'b1;
          end
        end
        S_XFER: begin
          if (w_rd) begin
            r_count <= r_count + 1'b1;
            if (r_count == BURSTWIDTH'(MAX_BURST - 1)) begin
              r_last  <= r_grant;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (!w_grant_ne) begin
            r_last  <= r_grant;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_rd) begin
      r_out_data  <= w_head;
      r_out_src   <= r_grant;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.src_re    = w_src_re;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_valid = r_out_valid;
  assign busy          = r_busy;
  assign grant         = r_grant;

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Directed bench: queue-modelled fifo_sync sources, scoreboard of expected {src,data} words per test.
module tb_fifo_drain_arb;
  localparam int NS = 4;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          enable = 1'b1;
  logic [NS-1:0] src_mask = 4'hF;
  logic          busy;
  logic [1:0]    grant;

  fifo_drain_arb_if #(.NUM_SRC(NS), .DATAWIDTH(DW), .SRCWIDTH(2)) bus ();

  fifo_drain_arb #(.NUM_SRC(NS), .DATAWIDTH(DW), .MAX_BURST(8), .SRCWIDTH(2), .BURSTWIDTH(4)) dut (
    .clk      (clk),
    .reset_l  (reset_l),
    .enable   (enable),
    .src_mask (src_mask),
    .bus      (bus),
    .busy     (busy),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq [NS][$];
  int            fill_seq [NS];
  int            exp_seq [NS];
  logic [19:0]   rcv [$];
  int            rcv_cyc [$];
  logic [19:0]   exp_q [$];
  logic [NS-1:0] re_s = '0;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, nreads = 0, busy_rise = 0, hold_viol = 0, inv_viol = 0, stall_cnt = 0;
  logic prev_v = 0, prev_r = 0, prev_busy = 0;
  logic [DW-1:0] prev_d = '0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: pop on the re seen before the edge, then present registered ne/head
  initial begin
    bus.src_ne = '0;
    bus.src_data = '0;
    bus.out_ready = 1'b1;
  end

  always begin
    @(posedge clk); #1;
    for (int i = 0; i < NS; i++) begin
      if (re_s[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      bus.src_ne[i] = (fq[i].size() > 0);
      bus.src_data[i*DW +: DW] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
    re_s = '0;
  end

  always begin
    @(negedge clk); #4;
    cyc++;
    if (reset_l) begin
      if ((bus.src_re & ~bus.src_ne) != '0) inv_viol++;
      if ($countones(bus.src_re) > 1) inv_viol++;
      re_s = bus.src_re;
      nreads += $countones(bus.src_re);
      if (prev_v && !prev_r && (!bus.out_valid || bus.out_data !== prev_d)) hold_viol++;
      if (bus.out_valid && !bus.out_ready) stall_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        rcv.push_back({bus.out_src, bus.out_data});
        rcv_cyc.push_back(cyc);
      end
      if (busy && !prev_busy) busy_rise++;
      prev_v = bus.out_valid;
      prev_r = bus.out_ready;
      prev_d = bus.out_data;
      prev_busy = busy;
    end else begin
      re_s = '0;
      prev_v = 1'b0;
      prev_busy = 1'b0;
    end
  end

  task automatic fill(int s, int n);
    for (int j = 0; j < n; j++) begin
      fq[s].push_back({2'(s), 16'(fill_seq[s])});
      fill_seq[s]++;
    end
  endtask

  task automatic exp_burst(int s, int n);
    for (int j = 0; j < n; j++) begin
      exp_q.push_back({2'(s), 2'(s), 16'(exp_seq[s])});
      exp_seq[s]++;
    end
  endtask

  task automatic wait_words(string tag, int n, int budget);
    int c = 0;
    while (rcv.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (rcv.size() < n) check({tag, "_timeout"}, 64'(rcv.size()), 64'(n));
  endtask

  task automatic check_stream(string tag);
    int bad = 0;
    check({tag, "_len"}, 64'(rcv.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rcv.size(); i++)
      if (rcv[i] !== exp_q[i]) bad++;
    check({tag, "_order"}, 64'(bad), 64'd0);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    reset_l = 1'b0;
    for (int i = 0; i < NS; i++) begin
      fq[i].delete();
      fill_seq[i] = 0;
      exp_seq[i] = 0;
    end
    rcv.delete();
    rcv_cyc.delete();
    exp_q.delete();
    nreads = 0; busy_rise = 0; hold_viol = 0; stall_cnt = 0;
    enable = 1'b1;
    src_mask = 4'hF;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_rst_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_rst_busy"}, 64'(busy), 64'd0);
    check({tag, "_rst_grant"}, 64'(grant), 64'd0);
    check({tag, "_rst_src"}, 64'(bus.out_src), 64'd0);
    check({tag, "_rst_data"}, 64'(bus.out_data), 64'd0);
    check({tag, "_rst_re"}, 64'(bus.src_re), 64'd0);
    reset_l = 1'b1;
  endtask

  initial begin
    // single source, short burst ending on empty
    do_reset("t1");
    fill(1, 3);
    exp_burst(1, 3);
    wait_words("t1", 3, 50);
    repeat (4) @(negedge clk);
    check_stream("t1");
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_grant", 64'(grant), 64'd1);
    check("t1_reads", 64'(nreads), 64'd3);

    // four full sources, round robin 8-word bursts then 4-word tails
    do_reset("t2");
    for (int s = 0; s < NS; s++) fill(s, 20);
    for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) exp_burst(s, 8);
    for (int s = 0; s < NS; s++) exp_burst(s, 4);
    wait_words("t2", 80, 400);
    check_stream("t2");
    if (rcv_cyc.size() == 80)
      check("t2_bubbles", 64'(rcv_cyc[79] - rcv_cyc[0] + 1 - 80), 64'd14);

    // lone source re-granted: 8,8,4
    do_reset("t3");
    fill(2, 20);
    exp_burst(2, 20);
    wait_words("t3", 20, 200);
    repeat (4) @(negedge clk);
    check_stream("t3");
    if (rcv_cyc.size() == 20)
      check("t3_bubbles", 64'(rcv_cyc[19] - rcv_cyc[0] + 1 - 20), 64'd2);
    check("t3_grants", 64'(busy_rise), 64'd3);

    // out_ready toggling
    do_reset("t4");
    fill(0, 10);
    exp_burst(0, 10);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.out_ready = (c % 2 == 0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    wait_words("t4", 10, 100);
    check_stream("t4");
    check("t4_hold", 64'(hold_viol), 64'd0);
    check("t4_stalled", 64'(stall_cnt > 0), 64'd1);

    // mask out source 1, drop enable mid-burst
    do_reset("t5");
    src_mask = 4'b1101;
    for (int s = 0; s < NS; s++) fill(s, 16);
    exp_burst(0, 8);
    exp_burst(2, 8); exp_burst(3, 8); exp_burst(0, 8); exp_burst(2, 8); exp_burst(3, 8);
    wait_words("t5a", 3, 50);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_burst_done", 64'(rcv.size()), 64'd8);
    check("t5_busy_off", 64'(busy), 64'd0);
    check("t5_valid_off", 64'(bus.out_valid), 64'd0);
    enable = 1'b1;
    wait_words("t5b", 48, 400);
    repeat (4) @(negedge clk);
    check_stream("t5");
    check("t5_src1_left", 64'(fq[1].size()), 64'd16);

    // reset mid-burst after the third read
    do_reset("t6");
    fill(2, 10);
    begin
      int c = 0;
      while (nreads < 3 && c < 50) begin
        @(negedge clk);
        c++;
      end
    end
    check("t6_reads", 64'(nreads), 64'd3);
    check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
    #1 reset_l = 1'b0;
    #1;
    check("t6_async_valid", 64'(bus.out_valid), 64'd0);
    check("t6_async_re", 64'(bus.src_re), 64'd0);
    check("t6_async_busy", 64'(busy), 64'd0);
    rcv.delete();
    rcv_cyc.delete();
    fill(0, 4);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;
    exp_seq[2] = 3;
    exp_burst(0, 4);
    exp_burst(2, 7);
    wait_words("t6", 11, 100);
    check_stream("t6");

    check("inv_re_onehot_ne", 64'(inv_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
